multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
//  Control FSM for the multi-cycle RV32I datapath. It receives op/func3/func7 from the
//  latched instruction register plus the ALU zero flag, and drives every datapath
//  select, write-enable and ALU code. Each instruction takes 3-5 clocks. Illegal opcodes
//  park the FSM in HALT.
// PARAMETERS
//  RESET_STATE  4'd0 (FETCH)  state entered on reset
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  synchronous reset, active-low (rst==0 at posedge clears state)
//  op          in   7  instr[6:0]
//  func3       in   3  instr[14:12]
//  func7       in   7  instr[31:25]
//  zero        in   1  ALU zero flag, combinational from current ALU result
//  pcwrite     out  1  PC register load enable
//  adrsel      out  1  memory address: 0=PC, 1=ALUOut
//  wedata      out  1  data memory write enable
//  irwrite     out  1  IR + OldPC load enable
//  wereg       out  1  register file write enable
//  resultsel   out  2  00=ALUOut 01=MDR 10=ALU result 11=imm
//  alusela     out  2  00=PC 01=OldPC 10=RD1(A reg)
//  aluselb     out  2  00=RD2(B reg) 01=imm 10=const 4
//  extend_func out  3  000=I 001=S 010=B 011=J 100=U
//  aluop       out  3  000 ADD 001 SUB 010 AND 011 OR 100 SLT 101 XOR 110 SLTU
//  halted      out  1  high while in HALT
// BEHAVIOUR
//  - State register only; all outputs are Moore decode of state+op/func3/func7, no latency.
//  - Unlisted outputs default to 0 in every state. On reset: state=FETCH, halted=0.
//  - FETCH: adrsel=0 irwrite=1 alusela=00 aluselb=10 aluop=ADD resultsel=10 pcwrite=1 -> DECODE.
//  - DECODE: alusela=01 aluselb=01 extend_func=B aluop=ADD (ALUOut=branch target). Next:
//      0110011->EXEC_R; 0010011->EXEC_I; 0000011/0100011->MEM_ADR; 1100011->BRANCH;
//      1101111->JAL; 1100111->JALR; 0110111->LUI; any other op->HALT.
//  - EXEC_R: alusela=10 aluselb=00; func3/func7 decode: 000+f7[5]=0 ADD, 000+f7[5]=1 SUB,
//      111 AND, 110 OR, 010 SLT, 100 XOR, 011 SLTU; other func3 -> HALT next. -> ALU_WB.
//  - EXEC_I: like EXEC_R with aluselb=01, extend_func=I, func7 ignored (no SUBI) -> ALU_WB.
//  - ALU_WB: resultsel=00 wereg=1 -> FETCH.
//  - MEM_ADR: alusela=10 aluselb=01 aluop=ADD, extend_func=I (load) or S (store).
//      Load -> MEM_RD; store -> MEM_WR. Only func3=010 (word) is legal, else -> HALT.
//  - MEM_RD: adrsel=1 -> MEM_WB. MEM_WB: resultsel=01 wereg=1 -> FETCH.
//  - MEM_WR: adrsel=1 wedata=1 -> FETCH.
//  - BRANCH: alusela=10 aluselb=00 resultsel=00. beq(000)/bne(001) use SUB. blt(100)/bge(101)
//      use SLT, where zero=0 means less-than. pcwrite=1 when taken: beq&zero,
//      bne&!zero, blt&!zero, bge&zero. Other func3 -> HALT. -> FETCH.
//  - JAL: alusela=01 aluselb=10 aluop=ADD resultsel=00 wereg=1 (rd=OldPC+4).
//      Also extend_func=J with target computed in the same cycle via pcwrite=1 and
//      resultsel=10 is NOT used. JAL instead takes 2 states: JAL computes
//      ALUOut=OldPC+imm(J), then JAL_WB writes rd=OldPC+4 via ALU result (resultsel=10,
//      wereg=1) and pcwrite=1 with resultsel=00 is forbidden in the same cycle.
//      Required order: JAL (ALUOut<=target) -> JAL_LINK (rd<=OldPC+4 through ALU, resultsel=10,
//      wereg=1) -> JAL_PC (resultsel=00 pcwrite=1) -> FETCH.
//  - JALR: alusela=10 aluselb=01 extend_func=I aluop=ADD -> JAL_LINK (shared) -> JAL_PC.
//  - LUI: extend_func=U resultsel=11 wereg=1 -> FETCH.
//  - HALT: halted=1, all enables 0, stays until rst==0.
//  - Reset mid-instruction: the next state is FETCH unconditionally. Enables are decoded
//    from state, so no partial write occurs after the reset edge.
//  - Never assert wereg and wedata together. Never assert pcwrite outside FETCH/BRANCH/JAL_PC.
// STRUCTURE
//  - Shared package: state localparams (4-bit, 16 codes), opcode constants, aluop/immsrc/
//    resultsel/alusel encodings. The datapath ALU and imm extender use the same values.
//  - One sub-module, alu_decoder (op, func3, func7 -> aluop, illegal flag), reused by EXEC_R/I.
// TESTING
//  - rst=0 for 2 clks mid-MEM_RD, then release -> state FETCH, irwrite=1, pcwrite=1, wereg=0.
//  - op=0110011 f3=000 f7=0100000 -> FETCH,DECODE,EXEC_R(aluop=001),ALU_WB(wereg=1): 4 clks.
//  - op=0000011 f3=010 -> 5 clks, wereg pulses only in MEM_WB, resultsel=01.
//    op=0100011 -> 4 clks, wedata=1 only in MEM_WR.
//  - BRANCH beq zero=1 -> pcwrite=1. bne zero=1 -> pcwrite=0. blt zero=0 -> pcwrite=1, aluop=100.
//  - jal -> JAL,JAL_LINK,JAL_PC sequence. jalr aluselb=01/extend_func=I. lui: 3 clks, resultsel=11.
//  - op=0000000 -> HALT after DECODE, halted=1, all enables 0 for 20 clks.
//    Also f3=001 load -> HALT.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// States, opcodes and datapath select codes used by controller and datapath.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADR  = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JAL_LINK = 4'd11,
    S_JAL_PC   = 4'd12,
    S_JALR     = 4'd13,
    S_LUI      = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Opcode dispatch out of DECODE; unknown opcodes park in HALT.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t s;
    s = S_HALT;
    unique case (1'b1)
      (op == OP_R):      s = S_EXEC_R;
      (op == OP_I):      s = S_EXEC_I;
      (op == OP_LOAD):   s = S_MEM_ADR;
      (op == OP_STORE):  s = S_MEM_ADR;
      (op == OP_BRANCH): s = S_BRANCH;
      (op == OP_JAL):    s = S_JAL;
      (op == OP_JALR):   s = S_JALR;
      (op == OP_LUI):    s = S_LUI;
      default:           s = S_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decode for R-type and I-type arithmetic.
// Ports: op/func3/func7 in; aluop and illegal (unsupported func3) out.
module alu_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] aluop,
  output logic       illegal
);

  // Only func7[5] selects SUB; the other bits carry no meaning here.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  logic is_sub;
  assign is_sub = (op == OP_R) && func7[5];

  always_comb begin
    aluop   = ALU_ADD;
    illegal = 1'b0;
    unique case (func3)
      3'b000:  aluop = is_sub ? ALU_SUB : ALU_ADD;
      3'b111:  aluop = ALU_AND;
      3'b110:  aluop = ALU_OR;
      3'b010:  aluop = ALU_SLT;
      3'b100:  aluop = ALU_XOR;
      3'b011:  aluop = ALU_SLTU;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath.
// Ports: clk, rst (sync, active-low), op/func3/func7/zero in; datapath controls out.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsel,
  output logic       wedata,
  output logic       irwrite,
  output logic       wereg,
  output logic [1:0] resultsel,
  output logic [1:0] alusela,
  output logic [1:0] aluselb,
  output logic [2:0] extend_func,
  output logic [2:0] aluop,
  output logic       halted
);

  state_t state;
  state_t next;

  logic [2:0] dec_aluop;
  logic       dec_illegal;

  alu_decoder u_alu_dec (
    .op      (op),
    .func3   (func3),
    .func7   (func7),
    .aluop   (dec_aluop),
    .illegal (dec_illegal)
  );

  logic       is_load;
  logic       mem_ok;
  logic [2:0] br_aluop;
  logic       br_taken;
  logic       br_illegal;

  assign is_load = (op == OP_LOAD);
  assign mem_ok  = (func3 == 3'b010);

  // blt/bge run SLT: zero=0 means the SLT result was 1 (less-than).
  always_comb begin
    br_aluop   = ALU_ADD;
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    unique case (func3)
      3'b000: begin
        br_aluop = ALU_SUB;
        br_taken = zero;
      end
      3'b001: begin
        br_aluop = ALU_SUB;
        br_taken = !zero;
      end
      3'b100: begin
        br_aluop = ALU_SLT;
        br_taken = !zero;
      end
      3'b101: begin
        br_aluop = ALU_SLT;
        br_taken = zero;
      end
      default: br_illegal = 1'b1;
    endcase
  end

  always_comb begin
    next = state;
    unique case (state)
      S_FETCH:    next = S_DECODE;
      S_DECODE:   next = decode_next(op);
      S_EXEC_R:   next = dec_illegal ? S_HALT : S_ALU_WB;
      S_EXEC_I:   next = dec_illegal ? S_HALT : S_ALU_WB;
      S_ALU_WB:   next = S_FETCH;
      S_MEM_ADR: begin
        if (!mem_ok)      next = S_HALT;
        else if (is_load) next = S_MEM_RD;
        else              next = S_MEM_WR;
      end
      S_MEM_RD:   next = S_MEM_WB;
      S_MEM_WB:   next = S_FETCH;
      S_MEM_WR:   next = S_FETCH;
      S_BRANCH:   next = br_illegal ? S_HALT : S_FETCH;
      S_JAL:      next = S_JAL_LINK;
      S_JALR:     next = S_JAL_LINK;
      S_JAL_LINK: next = S_JAL_PC;
      S_JAL_PC:   next = S_FETCH;
      S_LUI:      next = S_FETCH;
      S_HALT:     next = S_HALT;
      default:    next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= state_t'(RESET_STATE);
    else      state <= next;
  end

  // Outputs decode from state only (plus instruction fields and zero),
  // so a reset edge takes effect on all enables immediately.
  always_comb begin
    pcwrite     = 1'b0;
    adrsel      = 1'b0;
    wedata      = 1'b0;
    irwrite     = 1'b0;
    wereg       = 1'b0;
    resultsel   = RES_ALUOUT;
    alusela     = SRCA_PC;
    aluselb     = SRCB_RD2;
    extend_func = IMM_I;
    aluop       = ALU_ADD;
    halted      = 1'b0;
    unique case (state)
      S_FETCH: begin
        irwrite   = 1'b1;
        aluselb   = SRCB_FOUR;
        resultsel = RES_ALU;
        pcwrite   = 1'b1;
      end
      S_DECODE: begin
        alusela     = SRCA_OLDPC;
        aluselb     = SRCB_IMM;
        extend_func = IMM_B;
      end
      S_EXEC_R: begin
        alusela = SRCA_RD1;
        aluop   = dec_aluop;
      end
      S_EXEC_I: begin
        alusela = SRCA_RD1;
        aluselb = SRCB_IMM;
        aluop   = dec_aluop;
      end
      S_ALU_WB: wereg = 1'b1;
      S_MEM_ADR: begin
        alusela     = SRCA_RD1;
        aluselb     = SRCB_IMM;
        extend_func = is_load ? IMM_I : IMM_S;
      end
      S_MEM_RD: adrsel = 1'b1;
      S_MEM_WB: begin
        resultsel = RES_MDR;
        wereg     = 1'b1;
      end
      S_MEM_WR: begin
        adrsel = 1'b1;
        wedata = 1'b1;
      end
      S_BRANCH: begin
        alusela = SRCA_RD1;
        aluop   = br_aluop;
        pcwrite = br_taken && !br_illegal;
      end
      // Target goes to ALUOut first; link and PC update follow.
      S_JAL: begin
        alusela     = SRCA_OLDPC;
        aluselb     = SRCB_IMM;
        extend_func = IMM_J;
      end
      S_JALR: begin
        alusela = SRCA_RD1;
        aluselb = SRCB_IMM;
      end
      S_JAL_LINK: begin
        alusela   = SRCA_OLDPC;
        aluselb   = SRCB_FOUR;
        resultsel = RES_ALU;
        wereg     = 1'b1;
      end
      S_JAL_PC: pcwrite = 1'b1;
      S_LUI: begin
        extend_func = IMM_U;
        resultsel   = RES_IMM;
        wereg       = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed self-checking bench for multi_cycle_controller.
// Each task drives one instruction class and compares the packed outputs.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       pcwrite, adrsel, wedata, irwrite, wereg, halted;
  logic [1:0] resultsel, alusela, aluselb;
  logic [2:0] extend_func, aluop;

  int passed = 0;
  int total  = 0;

  multi_cycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .zero        (zero),
    .pcwrite     (pcwrite),
    .adrsel      (adrsel),
    .wedata      (wedata),
    .irwrite     (irwrite),
    .wereg       (wereg),
    .resultsel   (resultsel),
    .alusela     (alusela),
    .aluselb     (aluselb),
    .extend_func (extend_func),
    .aluop       (aluop),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {pcwrite, adrsel, wedata, irwrite, wereg,
                 resultsel, alusela, aluselb,
                 extend_func, aluop, halted};

  function automatic logic [17:0] sig(
    input logic pcw, input logic adr, input logic wed,
    input logic irw, input logic wer, input logic [1:0] res,
    input logic [1:0] sa, input logic [1:0] sb,
    input logic [2:0] ext, input logic [2:0] aop,
    input logic h);
    return {pcw, adr, wed, irw, wer, res, sa, sb, ext, aop, h};
  endfunction

  localparam logic [17:0] E_FETCH  =
    sig(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_DECODE =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 0);
  localparam logic [17:0] E_SUB_R  =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0);
  localparam logic [17:0] E_ADD_R  =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_ANDI   =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b010, 0);
  localparam logic [17:0] E_ALU_WB =
    sig(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_ADR_L  =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_ADR_S  =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0);
  localparam logic [17:0] E_MEM_RD =
    sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_MEM_WB =
    sig(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_MEM_WR =
    sig(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_BEQ_T  =
    sig(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0);
  localparam logic [17:0] E_BNE_N  =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0);
  localparam logic [17:0] E_BLT_T  =
    sig(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b100, 0);
  localparam logic [17:0] E_JAL    =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b011, 3'b000, 0);
  localparam logic [17:0] E_JALR   =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_LINK   =
    sig(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_JAL_PC =
    sig(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  localparam logic [17:0] E_LUI    =
    sig(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000, 0);
  localparam logic [17:0] E_HALT   =
    sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z);
    op    = o;
    func3 = f3;
    func7 = f7;
    zero  = z;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0);
    step();
    step();
    rst = 1'b1;
    total++;
    if (outs !== E_FETCH)
      $display("FAIL reset_state got %h want %h", outs, E_FETCH);
    else passed++;
  endtask

  task automatic test_r_type();
    logic [17:0] e [4];
    e = '{E_FETCH, E_DECODE, E_SUB_R, E_ALU_WB};
    set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL r_sub cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e [8];
    e = '{E_FETCH, E_DECODE, E_ADD_R, E_ALU_WB,
          E_FETCH, E_DECODE, E_ANDI, E_ALU_WB};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) set_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0);
      if (i == 4) set_instr(7'b0010011, 3'b111, 7'b0100000, 1'b0);
      total++;
      if (outs !== e[i])
        $display("FAIL b2b cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_load();
    logic [17:0] e [5];
    e = '{E_FETCH, E_DECODE, E_ADR_L, E_MEM_RD, E_MEM_WB};
    set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL load cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_store();
    logic [17:0] e [4];
    e = '{E_FETCH, E_DECODE, E_ADR_S, E_MEM_WR};
    set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL store cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [3];
    logic        z  [3];
    logic [17:0] eb [3];
    logic [17:0] e  [3];
    f3 = '{3'b000, 3'b001, 3'b100};
    z  = '{1'b1, 1'b1, 1'b0};
    eb = '{E_BEQ_T, E_BNE_N, E_BLT_T};
    for (int b = 0; b < 3; b++) begin
      set_instr(7'b1100011, f3[b], 7'b0000000, z[b]);
      e = '{E_FETCH, E_DECODE, eb[b]};
      for (int i = 0; i < 3; i++) begin
        total++;
        if (outs !== e[i])
          $display("FAIL branch%0d cyc%0d got %h want %h",
                   b, i, outs, e[i]);
        else passed++;
        step();
      end
    end
  endtask

  task automatic test_jal();
    logic [17:0] e [5];
    e = '{E_FETCH, E_DECODE, E_JAL, E_LINK, E_JAL_PC};
    set_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL jal cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_jalr();
    logic [17:0] e [5];
    e = '{E_FETCH, E_DECODE, E_JALR, E_LINK, E_JAL_PC};
    set_instr(7'b1100111, 3'b000, 7'b0000000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL jalr cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_lui();
    logic [17:0] e [4];
    e = '{E_FETCH, E_DECODE, E_LUI, E_FETCH};
    set_instr(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL lui cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      if (i < 3) step();
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e [4];
    e = '{E_FETCH, E_DECODE, E_ADR_L, E_MEM_RD};
    set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL rst_mid cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      if (i < 3) step();
    end
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    total++;
    if (outs !== E_FETCH)
      $display("FAIL rst_mid_fetch got %h want %h", outs, E_FETCH);
    else passed++;
  endtask

  task automatic test_halt();
    set_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0);
    total++;
    if (outs !== E_FETCH)
      $display("FAIL halt_fetch got %h want %h", outs, E_FETCH);
    else passed++;
    step();
    total++;
    if (outs !== E_DECODE)
      $display("FAIL halt_decode got %h want %h", outs, E_DECODE);
    else passed++;
    step();
    for (int i = 0; i < 20; i++) begin
      total++;
      if (outs !== E_HALT)
        $display("FAIL halt_hold cyc%0d got %h want %h", i, outs, E_HALT);
      else passed++;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++;
    if (outs !== E_FETCH)
      $display("FAIL halt_exit got %h want %h", outs, E_FETCH);
    else passed++;
  endtask

  task automatic test_bad_load();
    logic [17:0] e [5];
    e = '{E_FETCH, E_DECODE, E_ADR_L, E_HALT, E_HALT};
    set_instr(7'b0000011, 3'b001, 7'b0000000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs !== e[i])
        $display("FAIL bad_load cyc%0d got %h want %h", i, outs, e[i]);
      else passed++;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++;
    if (outs !== E_FETCH)
      $display("FAIL bad_load_exit got %h want %h", outs, E_FETCH);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_jalr();
    test_lui();
    test_reset_mid();
    test_halt();
    test_bad_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
